// File: rtl/weight_memory_bank_if.sv
// Write port plus read request/response channels of the weight memory bank.
// master drives writes and requests; slave is the memory bank.
interface weight_memory_bank_if #(
    parameter int DATAW = 128,
    parameter int ADDRW = 6
);
    logic                 wen;
    logic [ADDRW-1:0]     waddr;
    logic [DATAW-1:0]     wdata;
    logic [DATAW/8-1:0]   wstrb;
    logic                 rd_req_valid;
    logic                 rd_req_ready;
    logic [ADDRW-1:0]     rd_req_addr;
    logic                 rd_rsp_valid;
    logic                 rd_rsp_ready;
    logic [DATAW-1:0]     rd_rsp_data;

    modport master (
        output wen, waddr, wdata, wstrb, rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  wen, waddr, wdata, wstrb, rd_req_valid, rd_req_addr, rd_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data
    );
endinterface

// File: rtl/weight_memory_bank.sv
// Weight store: synchronous RAM with byte-strobed writes, buffered in-order read
// responses with backpressure, and a run-time fill sequencer.
module weight_memory_bank #(
    parameter int DATAW         = 128,
    parameter int DEPTH         = 64,
    parameter int ADDRW         = $clog2(DEPTH),
    parameter bit INIT_ON_RESET = 1'b1,
    parameter int RSP_DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_start,
    input  logic [DATAW-1:0] init_value,
    output logic             init_busy,
    weight_memory_bank_if.slave bus
);
    localparam int NBYTES = DATAW / 8;
    localparam int PTRW   = $clog2(RSP_DEPTH);
    localparam int CNTW   = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW:0]   DEPTH_L   = (ADDRW + 1)'(DEPTH);
    localparam logic [PTRW-1:0]  PTR_LAST  = PTRW'(RSP_DEPTH - 1);
    localparam logic [CNTW-1:0]  RSP_FULL  = CNTW'(RSP_DEPTH);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic [ADDRW-1:0] init_addr, init_addr_nxt;
    logic [DATAW-1:0] mem [DEPTH];
    logic [DATAW-1:0] rsp_buf [RSP_DEPTH];
    logic [PTRW-1:0]  wptr, rptr;
    logic [CNTW-1:0]  count;
    logic             run, wr_ok, rd_ok, fwd, push, pop;
    logic [DATAW-1:0] rd_word, merged;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            init_addr <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= init_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        init_addr_nxt = init_addr;
        init_busy     = 1'b0;
        case (state)
            ST_RESET: state_nxt = INIT_ON_RESET ? ST_INIT : ST_RUN;
            ST_INIT: begin
                init_busy     = 1'b1;
                init_addr_nxt = init_addr + 1'b1;
                if (init_addr == LAST_ADDR) begin
                    state_nxt     = ST_RUN;
                    init_addr_nxt = '0;
                end
            end
            ST_RUN: if (init_start) state_nxt = ST_INIT;
            default: state_nxt = ST_RESET;
        endcase
    end

    assign run   = (state == ST_RUN);
    assign wr_ok = run && bus.wen && ({1'b0, bus.waddr} < DEPTH_L);
    assign rd_ok = {1'b0, bus.rd_req_addr} < DEPTH_L;
    assign fwd   = wr_ok && (bus.waddr == bus.rd_req_addr);

    // Same-cycle write to the read address is merged byte-wise into the response.
    always_comb begin
        rd_word = rd_ok ? mem[bus.rd_req_addr] : '0;
        merged  = rd_word;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (fwd && bus.wstrb[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_addr] <= init_value;
        end else if (wr_ok) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (bus.wstrb[b]) mem[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.rd_req_ready = run && (count < RSP_FULL);
    assign bus.rd_rsp_valid = (count != '0);
    assign bus.rd_rsp_data  = rsp_buf[rptr];
    assign push = bus.rd_req_valid && bus.rd_req_ready;
    assign pop  = bus.rd_rsp_valid && bus.rd_rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) rsp_buf[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                rsp_buf[wptr] <= merged;
                wptr          <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_weight_memory_bank.sv
// Directed bench for weight_memory_bank: fill sequencer, strobed writes,
// read latency/throughput, backpressure, drain during fill, reset mid-fill.
module tb_weight_memory_bank;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init_start = 1'b0;
    logic [127:0] init_value = '0;
    logic         init_busy;
    int           n_total = 0;
    int           n_bad = 0;

    weight_memory_bank_if #(.DATAW(128), .ADDRW(6)) bus ();

    weight_memory_bank #(
        .DATAW(128), .DEPTH(64), .INIT_ON_RESET(1'b1), .RSP_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .init_value(init_value),
        .init_busy(init_busy), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [127:0] d, input logic [15:0] s);
        @(negedge clk);
        bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
        @(posedge clk); #1;
        bus.wen = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [127:0] d, output logic ok);
        int i;
        @(negedge clk);
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = a; bus.rd_rsp_ready = 1'b1;
        i = 0;
        while (!bus.rd_req_ready && i < 50) begin @(negedge clk); i++; end
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        i = 0;
        while (!bus.rd_rsp_valid && i < 50) begin @(posedge clk); #1; i++; end
        ok = bus.rd_rsp_valid;
        d  = bus.rd_rsp_data;
        @(posedge clk); #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (init_busy) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [127:0] exp);
        logic [127:0] d;
        logic ok;
        do_read(a, d, ok);
        check({tag, "_valid"}, 128'(ok), 128'd1);
        check(tag, d, exp);
    endtask

    initial begin
        int cnt, k, m, acc, changed, seen, bad_rdy, n;
        int acc_c[8];
        int rsp_c[8];
        logic [127:0] rsp_d[8];
        logic [127:0] first, got0, got1;
        logic rdy;

        bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_rsp_ready = 1'b0;
        init_value = pat(8'h01);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  128'(init_busy), 128'd0);
        check("rst_ready", 128'(bus.rd_req_ready), 128'd0);
        check("rst_valid", 128'(bus.rd_rsp_valid), 128'd0);
        check("rst_data",  bus.rd_rsp_data, '0);

        @(negedge clk); rst = 1'b1;
        count_busy(cnt);
        check("init_cycles", 128'(cnt), 128'd64);
        read_check("init_a0",  6'd0,  pat(8'h01));
        read_check("init_a31", 6'd31, pat(8'h01));
        read_check("init_a63", 6'd63, pat(8'h01));

        for (int i = 0; i < 8; i++) do_write(6'(10 + i), pat(8'(8'hA0 + i)), 16'hFFFF);

        // back-to-back reads, response ready held high
        k = 0; m = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.rd_rsp_ready = 1'b1;
            if (k < 8) begin bus.rd_req_valid = 1'b1; bus.rd_req_addr = 6'(10 + k); end
            else bus.rd_req_valid = 1'b0;
            rdy = bus.rd_req_ready;
            @(posedge clk); #1;
            if (bus.rd_req_valid && rdy && k < 8) begin acc_c[k] = c; k++; end
            if (bus.rd_rsp_valid && m < 8) begin rsp_d[m] = bus.rd_rsp_data; rsp_c[m] = c; m++; end
        end
        bus.rd_req_valid = 1'b0;
        check("b2b_accepts", 128'(k), 128'd8);
        check("b2b_rsps", 128'(m), 128'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_acc_cyc%0d", i), 128'(acc_c[i]), 128'(i));
            check($sformatf("b2b_lat%0d", i), 128'(rsp_c[i]), 128'(acc_c[i]));
            check($sformatf("b2b_data%0d", i), rsp_d[i], pat(8'(8'hA0 + i)));
        end

        // backpressure: response ready low for 10 cycles
        acc = 0; changed = 0; seen = 0; first = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.rd_rsp_ready = 1'b0;
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr = 6'(10 + acc);
            rdy = bus.rd_req_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
            if (bus.rd_rsp_valid) begin
                if (seen == 0) begin first = bus.rd_rsp_data; seen = 1; end
                else if (bus.rd_rsp_data !== first) changed = 1;
            end
        end
        check("bp_accepts", 128'(acc), 128'd2);
        check("bp_ready_low", 128'(bus.rd_req_ready), 128'd0);
        check("bp_stable", 128'(changed), 128'd0);
        check("bp_head", first, pat(8'hA0));
        @(negedge clk);
        bus.rd_req_valid = 1'b0; bus.rd_rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_valid1", 128'(bus.rd_rsp_valid), 128'd1);
        check("bp_rel_data1", bus.rd_rsp_data, pat(8'hA1));
        @(posedge clk); #1;
        check("bp_rel_empty", 128'(bus.rd_rsp_valid), 128'd0);

        // fill two buffer entries, then re-run the sequencer with zeros
        acc = 0;
        for (int c = 0; c < 10 && acc < 2; c++) begin
            @(negedge clk);
            bus.rd_rsp_ready = 1'b0; bus.rd_req_valid = 1'b1;
            bus.rd_req_addr = 6'(12 + acc);
            rdy = bus.rd_req_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
        end
        check("drain_fill", 128'(acc), 128'd2);
        @(negedge clk);
        bus.rd_req_valid = 1'b0; init_value = '0; init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        cnt = 0; bad_rdy = 0; n = 0; got0 = '0; got1 = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!init_busy) begin
                bus.wen = 1'b0; bus.rd_req_valid = 1'b0;
                break;
            end
            cnt++;
            if (bus.rd_req_ready) bad_rdy++;
            bus.wen = 1'b1; bus.waddr = 6'd30; bus.wdata = '1; bus.wstrb = '1;
            bus.rd_req_valid = 1'b1; bus.rd_req_addr = 6'd14;
            bus.rd_rsp_ready = (c >= 3);
            if (bus.rd_rsp_ready && bus.rd_rsp_valid) begin
                if (n == 0) got0 = bus.rd_rsp_data;
                else got1 = bus.rd_rsp_data;
                n++;
            end
        end
        check("fill_cycles", 128'(cnt), 128'd64);
        check("fill_ready_low", 128'(bad_rdy), 128'd0);
        check("drain_count", 128'(n), 128'd2);
        check("drain_data0", got0, pat(8'hA2));
        check("drain_data1", got1, pat(8'hA3));
        @(posedge clk); #1;
        check("fill_no_req", 128'(bus.rd_rsp_valid), 128'd0);
        read_check("fill_wen_ign", 6'd30, '0);

        do_write(6'd5, '1, 16'h00F0);
        read_check("strobe_a5", 6'd5, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);

        // write and read the same address in one cycle
        @(negedge clk);
        bus.wen = 1'b1; bus.waddr = 6'd6; bus.wdata = pat(8'hAB); bus.wstrb = 16'h000F;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 6'd6; bus.rd_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.wen = 1'b0; bus.rd_req_valid = 1'b0;
        check("wfirst_valid", 128'(bus.rd_rsp_valid), 128'd1);
        check("wfirst_data", bus.rd_rsp_data, 128'h0000_0000_0000_0000_0000_0000_ABAB_ABAB);
        @(posedge clk); #1;

        // reset part-way through a fill
        @(negedge clk);
        init_value = pat(8'h55); init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy",  128'(init_busy), 128'd0);
        check("mid_rst_ready", 128'(bus.rd_req_ready), 128'd0);
        check("mid_rst_valid", 128'(bus.rd_rsp_valid), 128'd0);
        check("mid_rst_data",  bus.rd_rsp_data, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        count_busy(cnt);
        check("refill_cycles", 128'(cnt), 128'd64);
        read_check("refill_a0",  6'd0,  pat(8'h55));
        read_check("refill_a5",  6'd5,  pat(8'h55));
        read_check("refill_a63", 6'd63, pat(8'h55));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
